// File: rtl/pio_pkg.sv
// Shared definitions for the multi-channel Avalon-MM PIO bank: register map,
// edge-capture modes and parameter-derived width helpers.
package pio_pkg;

  // Per-channel register offsets, address[1:0]
  typedef enum logic [1:0] {
    REG_DATA = 2'd0,
    REG_IN   = 2'd1,
    REG_EDGE = 2'd2,
    REG_MASK = 2'd3
  } reg_e;

  // Edge types the capture logic can be built for
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Channel-select field width; a single channel still gets one address bit
  function automatic int ch_width(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

  // Byte-enable width; registers narrower than a byte still get one lane
  function automatic int be_width(input int data_w);
    return (data_w < 8) ? 1 : data_w / 8;
  endfunction

endpackage

// File: rtl/pio_channel.sv
// One PIO channel: byte-enabled output register, irq mask, input synchroniser,
// sticky edge capture and this channel's contribution to the shared irq.
module pio_channel
  import pio_pkg::*;
#(
  parameter int              DATA_W    = 32,
  parameter int              BE_W      = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int              EDGE_MODE = EDGE_RISE
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              guard_active,
  input  logic              wr_en,
  input  logic [1:0]        reg_sel,
  input  logic [BE_W-1:0]   byteenable,
  input  logic [DATA_W-1:0] writedata,
  input  logic [DATA_W-1:0] in_async,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              irq_term
);

  logic [DATA_W-1:0] be_mask;
  logic [DATA_W-1:0] out_q;
  logic [DATA_W-1:0] mask_q;
  logic [DATA_W-1:0] sync1_q;
  logic [DATA_W-1:0] sync2_q;
  logic [DATA_W-1:0] prev_q;
  logic [DATA_W-1:0] edge_q;
  logic [DATA_W-1:0] edge_hit;
  logic [DATA_W-1:0] edge_clr;
  logic              data_we;
  logic              mask_we;
  logic              edge_we;

  // Expand byte enables to a bit mask; bits past the last full byte follow the top lane
  for (genvar i = 0; i < DATA_W; i++) begin : g_be
    localparam int LANE = ((i / 8) < BE_W) ? (i / 8) : (BE_W - 1);
    assign be_mask[i] = byteenable[LANE];
  end

  assign data_we = wr_en && (reg_sel == REG_DATA);
  assign mask_we = wr_en && (reg_sel == REG_MASK);
  assign edge_we = wr_en && (reg_sel == REG_EDGE);

  // Writable registers: only enabled byte lanes take the new data
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of the order the always blocks are evaluated.
    if (!reset_n) begin
      out_q  <= RESET_VAL;
      mask_q <= '0;
    end else begin
      if (data_we) out_q  <= (out_q  & ~be_mask) | (writedata & be_mask);
      if (mask_we) mask_q <= (mask_q & ~be_mask) | (writedata & be_mask);
    end
  end

  // Two-flop synchroniser followed by the previous-value register for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= in_async;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Edge detect for the configured edge type, silenced while the post-reset guard runs
  always_comb begin
    // NOTE: default assignment first so no path through the block leaves
    // edge_hit unassigned, which would otherwise infer a latch.
    edge_hit = '0;
    case (EDGE_MODE)
      EDGE_FALL: edge_hit = ~sync2_q & prev_q;
      EDGE_ANY:  edge_hit = sync2_q ^ prev_q;
      default:   edge_hit = sync2_q & ~prev_q;
    endcase
    if (guard_active) edge_hit = '0;
  end

  assign edge_clr = edge_we ? (writedata & be_mask) : '0;

  // Sticky edge capture; a new edge in the same cycle as its clear keeps the bit set
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_q <= '0;
    else          edge_q <= (edge_q & ~edge_clr) | edge_hit;
  end

  // Register read view for the top-level read mux
  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_DATA: rd_data = out_q;
      REG_IN:   rd_data = sync2_q;
      REG_EDGE: rd_data = edge_q;
      REG_MASK: rd_data = mask_q;
      default:  rd_data = '0;
    endcase
  end

  assign out_data = out_q;
  assign irq_term = |(edge_q & mask_q);

endmodule

// File: rtl/avalon_pio_bank.sv
// Multi-channel Avalon-MM PIO slave. Decodes {channel, reg} addresses, owns the
// post-reset edge guard, the registered read path and the combined irq.
module avalon_pio_bank
  import pio_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                NUM_CH    = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int                EDGE_MODE = EDGE_RISE
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [ch_width(NUM_CH)+1:0]   address,
  input  logic                          chipselect,
  input  logic                          read,
  input  logic                          write_n,
  input  logic [be_width(DATA_W)-1:0]   byteenable,
  input  logic [DATA_W-1:0]             writedata,
  output logic [DATA_W-1:0]             readdata,
  input  logic [NUM_CH*DATA_W-1:0]      in_port,
  output logic [NUM_CH*DATA_W-1:0]      out_port,
  output logic                          irq
);

  localparam int CH_W   = ch_width(NUM_CH);
  localparam int BE_W   = be_width(DATA_W);
  localparam int ADDR_W = CH_W + 2;

  logic              wr_req;
  logic              rd_req;
  logic [CH_W-1:0]   ch_idx;
  logic [1:0]        reg_sel;
  logic [1:0]        guard_cnt;
  logic              guard_active;
  logic [DATA_W-1:0] ch_rd [NUM_CH];
  logic [NUM_CH-1:0] irq_terms;
  logic [DATA_W-1:0] rd_mux;

  assign wr_req  = chipselect & ~write_n;
  assign rd_req  = chipselect & read;
  assign ch_idx  = address[ADDR_W-1:2];
  assign reg_sel = address[1:0];

  // Post-reset guard: counts 3 -> 0 so inputs already high at reset are not seen as edges
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              guard_cnt <= 2'd3;
    else if (guard_cnt != 2'd0) guard_cnt <= guard_cnt - 2'd1;
  end

  assign guard_active = (guard_cnt != 2'd0);

  // One channel per slice of the packed in/out ports; unmatched channel indices never write
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pio_channel #(
      .DATA_W    (DATA_W),
      .BE_W      (BE_W),
      .RESET_VAL (RESET_VAL),
      .EDGE_MODE (EDGE_MODE)
    ) u_ch (
      .clk          (clk),
      .reset_n      (reset_n),
      .guard_active (guard_active),
      .wr_en        (wr_req && (ch_idx == CH_W'(c))),
      .reg_sel      (reg_sel),
      .byteenable   (byteenable),
      .writedata    (writedata),
      .in_async     (in_port[c*DATA_W +: DATA_W]),
      .out_data     (out_port[c*DATA_W +: DATA_W]),
      .rd_data      (ch_rd[c]),
      .irq_term     (irq_terms[c])
    );
  end

  // Read mux; a channel index with no channel behind it reads as zero
  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_idx == CH_W'(c)) rd_mux = ch_rd[c];
    end
  end

  // Registered read data (latency 1) and combined irq
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      if (rd_req) readdata <= rd_mux;
      irq <= |irq_terms;
    end
  end

endmodule

// File: tb/tb_avalon_pio_bank.sv
// Directed self-checking bench for avalon_pio_bank: 3 channels of 32 bits,
// rising-edge capture, non-zero output reset value.
module tb_avalon_pio_bank;
  import pio_pkg::*;

  localparam int          DATA_W = 32;
  localparam int          NUM_CH = 3;
  localparam int          W      = NUM_CH * DATA_W;
  localparam logic [31:0] RV     = 32'h5A5A_0000;

  logic          clk;
  logic          reset_n;
  logic [3:0]    address;
  logic          chipselect;
  logic          read;
  logic          write_n;
  logic [3:0]    byteenable;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  in_port;
  logic [W-1:0]  out_port;
  logic          irq;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] rd;

  avalon_pio_bank #(
    .DATA_W    (DATA_W),
    .NUM_CH    (NUM_CH),
    .RESET_VAL (RV),
    .EDGE_MODE (EDGE_RISE)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .read       (read),
    .write_n    (write_n),
    .byteenable (byteenable),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    chipselect = 1'b0;
    read       = 1'b0;
    write_n    = 1'b1;
    byteenable = 4'h0;
    writedata  = 32'h0;
  endtask

  task automatic bus_write(input int ch, input reg_e r, input logic [3:0] be, input logic [31:0] d);
    @(negedge clk);
    address    = {2'(ch), r};
    chipselect = 1'b1;
    write_n    = 1'b0;
    byteenable = be;
    writedata  = d;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_read(input int ch, input reg_e r, output logic [31:0] d);
    @(negedge clk);
    address    = {2'(ch), r};
    chipselect = 1'b1;
    read       = 1'b1;
    @(negedge clk);
    bus_idle();
    d = readdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    address = '0;
    bus_idle();
    in_port = '0;
    in_port[31:0] = 32'hFFFF_FFFF;

    // Reset state with ch0 inputs held high
    #23;
    check("rst_out_async", out_port, {RV, RV, RV});
    check("rst_readdata", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(10);
    check("rst_out", out_port, {RV, RV, RV});
    check("rst_irq", irq, 1'b0);
    bus_read(0, REG_EDGE, rd);
    check("rst_edge0", rd, 32'h0);
    bus_read(0, REG_IN, rd);
    check("in0_read", rd, 32'hFFFF_FFFF);
    bus_read(0, REG_MASK, rd);
    check("rst_mask0", rd, 32'h0);

    // Byte-enabled writes to ch2 DATA
    bus_write(2, REG_DATA, 4'b1111, 32'h0);
    bus_write(2, REG_DATA, 4'b0011, 32'hDEAD_BEEF);
    check("be_out_ch2", out_port, {32'h0000_BEEF, RV, RV});
    bus_read(2, REG_DATA, rd);
    check("be_read_ch2", rd, 32'h0000_BEEF);
    bus_write(2, REG_DATA, 4'b0100, 32'h1122_3344);
    check("be_lane2_ch2", out_port[95:64], 32'h0022_BEEF);

    // Simultaneous read and write of one register returns the old value
    @(negedge clk);
    address    = {2'd2, REG_DATA};
    chipselect = 1'b1;
    read       = 1'b1;
    write_n    = 1'b0;
    byteenable = 4'b1111;
    writedata  = 32'hCAFE_F00D;
    @(negedge clk);
    bus_idle();
    check("rdw_old", readdata, 32'h0022_BEEF);
    check("rdw_new_out", out_port[95:64], 32'hCAFE_F00D);
    idle(2);
    check("rd_hold", readdata, 32'h0022_BEEF);

    // Writes to IN are ignored and leave outputs alone
    bus_write(1, REG_IN, 4'b1111, 32'h1234_5678);
    check("in_write_ign", out_port, {32'hCAFE_F00D, RV, RV});

    // Rising edge on ch1 bit0: EDGE set 3 edges after the change, irq one later
    bus_write(1, REG_MASK, 4'b0001, 32'h1);
    bus_read(1, REG_MASK, rd);
    check("mask1_read", rd, 32'h1);
    @(negedge clk);
    in_port[32] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    address    = {2'd1, REG_EDGE};
    chipselect = 1'b1;
    read       = 1'b1;
    @(negedge clk);
    check("edge1_t2", readdata, 32'h0);
    check("irq_t3", irq, 1'b0);
    @(negedge clk);
    check("edge1_t3", readdata, 32'h1);
    check("irq_t4", irq, 1'b1);
    bus_idle();

    // Masking drops irq a cycle later; the edge stays pending
    bus_write(1, REG_MASK, 4'b0001, 32'h0);
    check("mask_off_t0", irq, 1'b1);
    idle(1);
    check("mask_off_t1", irq, 1'b0);
    bus_write(1, REG_MASK, 4'b0001, 32'h1);
    idle(1);
    check("mask_on_pend", irq, 1'b1);

    // Write-1-to-clear: irq falls two cycles after the write is presented
    bus_write(1, REG_EDGE, 4'b0001, 32'h1);
    check("clr_irq_t1", irq, 1'b1);
    idle(1);
    check("clr_irq_t2", irq, 1'b0);
    bus_read(1, REG_EDGE, rd);
    check("clr_edge1", rd, 32'h0);

    // New edge landing in the clear cycle: set wins
    @(negedge clk);
    in_port[32] = 1'b0;
    idle(4);
    in_port[32] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    address    = {2'd1, REG_EDGE};
    chipselect = 1'b1;
    write_n    = 1'b0;
    byteenable = 4'b0001;
    writedata  = 32'h1;
    @(negedge clk);
    bus_idle();
    idle(1);
    check("setwin_irq", irq, 1'b1);
    bus_read(1, REG_EDGE, rd);
    check("setwin_edge1", rd, 32'h1);

    // Channel 3 does not exist: writes ignored, reads return 0
    bus_write(3, REG_DATA, 4'b1111, 32'h0000_1234);
    check("oor_out", out_port, {32'hCAFE_F00D, RV, RV});
    for (int r = 0; r < 4; r++) begin
      bus_read(3, reg_e'(r), rd);
      check($sformatf("oor_read_r%0d", r), rd, 32'h0);
    end

    // Asynchronous reset in the middle of a write burst
    check("pre_rst_irq", irq, 1'b1);
    @(negedge clk);
    address    = {2'd0, REG_DATA};
    chipselect = 1'b1;
    write_n    = 1'b0;
    byteenable = 4'b1111;
    writedata  = 32'h0BAD_0BAD;
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_irq", irq, 1'b0);
    check("midrst_out", out_port, {RV, RV, RV});
    check("midrst_rd", readdata, 32'h0);
    bus_idle();
    in_port[32] = 1'b0;
    idle(2);
    reset_n = 1'b1;
    in_port[32] = 1'b1;
    idle(6);
    bus_read(1, REG_EDGE, rd);
    check("guard_edge1", rd, 32'h0);
    bus_read(0, REG_EDGE, rd);
    check("guard_edge0", rd, 32'h0);
    check("guard_irq", irq, 1'b0);

    // Capture works again once the guard has expired
    @(negedge clk);
    in_port[33] = 1'b1;
    idle(4);
    bus_read(1, REG_EDGE, rd);
    check("post_guard_edge1", rd, 32'h2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
